// File: rtl/router_reg_buf.sv
// Per-packet register stage of the 1x3 router: header decode, parity/length check and a hold buffer.
// Optional error-packet counter is enabled by defining ROUTER_REG_ERRCNT_EN.
module router_reg_buf #(
    parameter int DW         = 8,
    parameter int ADDR_W     = 2,
    parameter int LEN_W      = 6,
    parameter int HOLD_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              packet_valid,
    input  logic [DW-1:0]     data_in,
    output logic              busy,
    input  logic              fifo_full,
    output logic [DW-1:0]     dout,
    output logic              dout_valid,
    output logic [ADDR_W-1:0] dest_addr,
    output logic              low_packet_valid,
    output logic              parity_done,
    output logic              err,
    output logic              len_err,
    output logic [15:0]       err_cnt
);

    localparam int PTR_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
    localparam int CNT_W = $clog2(HOLD_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(HOLD_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(HOLD_DEPTH);
    localparam logic [LEN_W-1:0] LEN_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK
    } state_t;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Returns {overflow, next_count}; the count sticks at its maximum.
    function automatic logic [LEN_W:0] len_sat_inc(input logic [LEN_W-1:0] c);
        return (c == LEN_MAX) ? {1'b1, c} : {1'b0, c + 1'b1};
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] dest_addr_q, dest_addr_d;
    logic [LEN_W-1:0]  exp_len_q, exp_len_d;
    logic [LEN_W-1:0]  pay_cnt_q, pay_cnt_d;
    logic              ovf_q, ovf_d;
    logic [DW-1:0]     parity_q, parity_d;
    logic [DW-1:0]     pkt_parity_q, pkt_parity_d;
    logic              err_q, err_d;
    logic              len_err_q, len_err_d;
    logic              done_q, done_d;
    logic              lpv_q, lpv_d;

    logic [DW-1:0]     mem_q [HOLD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              accept;
    logic              pop;
    logic [LEN_W:0]    len_inc;

    assign busy       = (count_q == FULL_CNT) || (state_q == S_CHECK);
    assign accept     = !busy && ((state_q != S_IDLE) || packet_valid);
    assign dout_valid = (count_q != '0);
    assign pop        = dout_valid && !fifo_full;
    assign dout       = mem_q[rd_ptr_q];
    assign len_inc    = len_sat_inc(pay_cnt_q);

    assign dest_addr        = dest_addr_q;
    assign low_packet_valid = lpv_q;
    assign parity_done      = done_q;
    assign err              = err_q;
    assign len_err          = len_err_q;

    always_comb begin
        state_d      = state_q;
        dest_addr_d  = dest_addr_q;
        exp_len_d    = exp_len_q;
        pay_cnt_d    = pay_cnt_q;
        ovf_d        = ovf_q;
        parity_d     = parity_q;
        pkt_parity_d = pkt_parity_q;
        err_d        = err_q;
        len_err_d    = len_err_q;
        done_d       = done_q;
        lpv_d        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dest_addr_d = data_in[ADDR_W-1:0];
                    exp_len_d   = data_in[ADDR_W +: LEN_W];
                    parity_d    = data_in;
                    pay_cnt_d   = '0;
                    ovf_d       = 1'b0;
                    err_d       = 1'b0;
                    len_err_d   = 1'b0;
                    done_d      = 1'b0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (packet_valid) begin
                        parity_d  = parity_q ^ data_in;
                        pay_cnt_d = len_inc[LEN_W-1:0];
                        ovf_d     = ovf_q | len_inc[LEN_W];
                    end else begin
                        // Parity byte: stored for comparison, never folded into the running XOR.
                        pkt_parity_d = data_in;
                        lpv_d        = 1'b1;
                        state_d      = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                err_d     = (parity_q != pkt_parity_q);
                len_err_d = ovf_q || (pay_cnt_q != exp_len_q);
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!accept && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            dest_addr_q  <= '0;
            exp_len_q    <= '0;
            pay_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            parity_q     <= '0;
            pkt_parity_q <= '0;
            err_q        <= 1'b0;
            len_err_q    <= 1'b0;
            done_q       <= 1'b0;
            lpv_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            dest_addr_q  <= dest_addr_d;
            exp_len_q    <= exp_len_d;
            pay_cnt_q    <= pay_cnt_d;
            ovf_q        <= ovf_d;
            parity_q     <= parity_d;
            pkt_parity_q <= pkt_parity_d;
            err_q        <= err_d;
            len_err_q    <= len_err_d;
            done_q       <= done_d;
            lpv_q        <= lpv_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: contents are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef ROUTER_REG_ERRCNT_EN
    function automatic logic [15:0] err_cnt_sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic        chk_done_q;
    logic [15:0] err_cnt_q;

    // Flags settle on the CHECK edge, so the counter samples them one edge later.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            chk_done_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            chk_done_q <= (state_q == S_CHECK);
            if (chk_done_q && (err_q || len_err_q)) begin
                err_cnt_q <= err_cnt_sat_inc(err_cnt_q);
            end
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_router_reg_buf.sv
// Directed bench for router_reg_buf: packets, parity/length errors, backpressure and mid-packet reset.
module tb_router_reg_buf;

    typedef logic [7:0] bq_t [$];

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        packet_valid = 1'b0;
    logic [7:0]  data_in = '0;
    logic        busy;
    logic        fifo_full = 1'b0;
    logic [7:0]  dout;
    logic        dout_valid;
    logic [1:0]  dest_addr;
    logic        low_packet_valid;
    logic        parity_done;
    logic        err;
    logic        len_err;
    logic [15:0] err_cnt;

    int pass_cnt = 0;
    int total    = 0;
    int lpv_cnt  = 0;
    int got_idx  = 0;
    int exp_errs = 0;
    bq_t got_q;
    bq_t pl;
    bq_t ex;

    router_reg_buf #(.DW(8), .ADDR_W(2), .LEN_W(6), .HOLD_DEPTH(4)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .packet_valid    (packet_valid),
        .data_in         (data_in),
        .busy            (busy),
        .fifo_full       (fifo_full),
        .dout            (dout),
        .dout_valid      (dout_valid),
        .dest_addr       (dest_addr),
        .low_packet_valid(low_packet_valid),
        .parity_done     (parity_done),
        .err             (err),
        .len_err         (len_err),
        .err_cnt         (err_cnt)
    );

    always #5 clk = ~clk;

    // A pop happens at the next rising edge whenever this condition holds mid-cycle.
    always @(negedge clk) begin
        if (resetn && dout_valid && !fifo_full) got_q.push_back(dout);
        if (low_packet_valid) lpv_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic pv, input logic [7:0] d);
        int n;
        n = 0;
        packet_valid = pv;
        data_in      = d;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("send_timeout", busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic finish_pkt(input string tag, input logic [7:0] par,
                              input logic e_err, input logic e_lerr, input int lpv_base);
        send_byte(1'b0, par);
        check({tag, "_lpv_high"}, low_packet_valid, 1);
        @(posedge clk);
        #1;
        check({tag, "_parity_done"}, parity_done, 1);
        check({tag, "_err"}, err, e_err);
        check({tag, "_len_err"}, len_err, e_lerr);
        check({tag, "_lpv_pulses"}, lpv_cnt - lpv_base, 1);
        if (e_err || e_lerr) exp_errs++;
    endtask

    task automatic send_packet(input string tag, input logic [7:0] hdr, input bq_t p,
                               input logic [7:0] par, input logic [1:0] e_addr,
                               input logic e_err, input logic e_lerr);
        int base;
        base = lpv_cnt;
        send_byte(1'b1, hdr);
        check({tag, "_dest_addr"}, dest_addr, e_addr);
        check({tag, "_hdr_clears_err"}, {parity_done, err, len_err}, 0);
        foreach (p[i]) send_byte(1'b1, p[i]);
        finish_pkt(tag, par, e_err, e_lerr, base);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (dout_valid !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, dout_valid, 0);
    endtask

    task automatic check_stream(input string tag, input bq_t e);
        logic [7:0] obs;
        check({tag, "_count"}, got_q.size() - got_idx, e.size());
        foreach (e[i]) begin
            obs = (got_idx + i < got_q.size()) ? got_q[got_idx + i] : 8'hxx;
            check({tag, "_byte"}, obs, e[i]);
        end
        got_idx = got_q.size();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_dout_valid"}, dout_valid, 0);
        check({tag, "_dest_addr"}, dest_addr, 0);
        check({tag, "_flags"}, {low_packet_valid, parity_done, err, len_err}, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        resetn = 1'b1;

        // Good packet: addr 1, length 3, parity 0D^11^22^33 = 0D.
        pl = '{8'h11, 8'h22, 8'h33};
        send_packet("s1", 8'h0D, pl, 8'h0D, 2'd1, 1'b0, 1'b0);
        wait_drain("s1");
        ex = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        check_stream("s1_stream", ex);

        // Two back-to-back packets with a wrong parity byte.
        ex = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0E, 8'h0D, 8'h11, 8'h22, 8'h33, 8'h0E};
        send_packet("s2a", 8'h0D, pl, 8'h0E, 2'd1, 1'b1, 1'b0);
        send_packet("s2b", 8'h0D, pl, 8'h0E, 2'd1, 1'b1, 1'b0);
        wait_drain("s2");
        check_stream("s2_stream", ex);

        // Short payload with correct parity 0D^11^22 = 3E.
        pl = '{8'h11, 8'h22};
        send_packet("s3", 8'h0D, pl, 8'h3E, 2'd1, 1'b0, 1'b1);
        wait_drain("s3");
        ex = '{8'h0D, 8'h11, 8'h22, 8'h3E};
        check_stream("s3_stream", ex);

        // Zero-length packets: header 01 declares length 0, header 06 declares length 1 (addr 2).
        pl.delete();
        send_packet("zl_ok", 8'h01, pl, 8'h01, 2'd1, 1'b0, 1'b0);
        send_packet("zl_bad", 8'h06, pl, 8'h06, 2'd2, 1'b0, 1'b1);
        wait_drain("zl");
        ex = '{8'h01, 8'h01, 8'h06, 8'h06};
        check_stream("zl_stream", ex);

        // Backpressure: destination full for 10 cycles from the header.
        fifo_full = 1'b1;
        begin
            int base;
            base = lpv_cnt;
            send_byte(1'b1, 8'h0D);
            send_byte(1'b1, 8'h11);
            send_byte(1'b1, 8'h22);
            send_byte(1'b1, 8'h33);
            check("bp_busy_full", busy, 1);
            check("bp_head", {dout_valid, dout}, {1'b1, 8'h0D});
            packet_valid = 1'b0;
            data_in      = 8'h0D;
            repeat (6) @(posedge clk);
            #1;
            check("bp_still_busy", busy, 1);
            check("bp_no_pop", dout, 8'h0D);
            fifo_full = 1'b0;
            finish_pkt("bp", 8'h0D, 1'b0, 1'b0, base);
        end
        wait_drain("bp");
        ex = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        check_stream("bp_stream", ex);

        // Reset after the second payload byte aborts the packet.
        send_byte(1'b1, 8'h0D);
        send_byte(1'b1, 8'h11);
        send_byte(1'b1, 8'h22);
        resetn       = 1'b0;
        packet_valid = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state("midrst");
        resetn  = 1'b1;
        got_idx = got_q.size();
        pl = '{8'h11, 8'h22, 8'h33};
        send_packet("post_rst", 8'h0D, pl, 8'h0D, 2'd1, 1'b0, 1'b0);
        wait_drain("post_rst");
        ex = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        check_stream("post_rst_stream", ex);

        // Only errors after the mid-packet reset are counted; none occurred.
        exp_errs = 0;
        repeat (3) @(posedge clk);
        #1;
`ifdef ROUTER_REG_ERRCNT_EN
        pl = '{8'h11, 8'h22, 8'h33};
        send_packet("ec_a", 8'h0D, pl, 8'h0E, 2'd1, 1'b1, 1'b0);
        send_packet("ec_b", 8'h0D, pl, 8'h0E, 2'd1, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("err_cnt", err_cnt, exp_errs);
`else
        check("err_cnt_tied", err_cnt, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/router_reg_buf.md
Name: router_reg_buf

Overview:
Parametrised per-packet register/datapath stage of the 1x3 router. It sits between the source interface and the destination FIFOs, and contains its own packet FSM. It accepts header, payload and parity bytes and extracts the destination address and expected length from the header. Accepted bytes go through a HOLD_DEPTH-deep hold buffer, so the stage absorbs destination-FIFO backpressure, and it checks both parity and payload length.

Parameters:
DW, 8, data/byte width in bits
ADDR_W, 2, header bits [ADDR_W-1:0] = destination address
LEN_W, 6, header bits [ADDR_W+LEN_W-1:ADDR_W] = expected payload length (requires ADDR_W+LEN_W <= DW)
HOLD_DEPTH, 4, hold-buffer entries, >= 2, any integer

Ports:
clk  in  1  clock, all logic on rising edge
resetn  in  1  synchronous, active-low reset
packet_valid  in  1  source: high for header/payload, low on the cycle the parity byte is presented
data_in  in  DW  source byte
busy  out  1  combinational: source must hold data_in/packet_valid while high
fifo_full  in  1  destination FIFO full
dout  out  DW  head of hold buffer (show-ahead)
dout_valid  out  1  hold buffer non-empty; the FIFO writes dout when dout_valid && !fifo_full
dest_addr  out  ADDR_W  latched header address
low_packet_valid  out  1  1-cycle pulse when the parity byte is accepted
parity_done  out  1  check complete; held until the next header is accepted
err  out  1  parity mismatch; held until the next header is accepted
len_err  out  1  payload count != header length; held until the next header is accepted
err_cnt  out  16  error-packet counter (see Optional Feature)

Behaviour:
- Reset (resetn=0 at a clk edge): FSM=IDLE; buffer flushed (rd_ptr=wr_ptr=count=0); internal parity=0, payload count=0. All outputs are 0 except dout, which is don't-care while dout_valid=0.
- Reset mid-packet aborts the packet; the remainder of that packet is not recovered.
- Accept: a byte is accepted when !busy, and additionally in IDLE only when packet_valid=1. Every accepted byte is written to buffer[wr_ptr].
- busy = (count==HOLD_DEPTH) || state==CHECK.
- Pop: pop when dout_valid && !fifo_full. A simultaneous push and pop leaves count unchanged. Pointers wrap from HOLD_DEPTH-1 to 0.
- A push when count==HOLD_DEPTH is impossible (busy), even if a pop occurs in the same cycle.
- Latency: a byte accepted at edge N into an empty buffer appears on dout with dout_valid=1 after edge N; it pops at the first edge with !fifo_full.
- FSM IDLE: on header acceptance:
  - dest_addr, exp_len <= header fields
  - internal parity <= data_in
  - payload count <= 0
  - clear err, len_err, parity_done
  - go LOAD
- FSM LOAD:
  - accepted byte with packet_valid=1: payload; parity ^= data_in; count +1, saturating at 2^LEN_W-1 with an overflow flag set.
  - accepted byte with packet_valid=0: parity byte; latched into pkt_parity, not XORed; low_packet_valid pulses; go CHECK.
  - If packet_valid falls while busy, the source holds the parity byte; the FSM stays in LOAD until the byte is accepted.
- FSM CHECK (exactly 1 cycle):
  - err <= (parity != pkt_parity)
  - len_err <= overflow || (count != exp_len)
  - parity_done <= 1
  - go IDLE
- Zero-length packet: a header followed immediately by the parity byte is legal; len_err=0 iff exp_len=0.
- Back-to-back packets: a header may be accepted on the cycle after CHECK. Bytes of the previous packet still draining from the buffer are unaffected.

Optional Feature:
Macro ROUTER_REG_ERRCNT_EN.
- Defined: err_cnt increments by 1 in the cycle after CHECK when err||len_err, saturating at 16'hFFFF; reset to 0.
- Undefined: err_cnt tied to 0 and no counter logic is present; the port always exists.

Test Plan:
All scenarios use DW=8, ADDR_W=2, LEN_W=6, HOLD_DEPTH=4, fifo_full=0 unless stated.
1. Header 8'h0D, payload 11,22,33, parity 8'h0D -> dout sequence 0D,11,22,33,0D; dest_addr=1; low_packet_valid one pulse; parity_done=1, err=0, len_err=0.
2. Same packet with parity byte 8'h0E -> err=1, len_err=0; both clear when the next header is accepted.
3. Header 8'h0D with 2 payload bytes (11,22) and the correct parity 8'h3E -> err=0, len_err=1.
4. fifo_full=1 for 10 cycles from the header -> busy asserts once 4 bytes are buffered; the source holds; no loss or duplication; after release the buffer drains 1/cycle in order.
5. resetn=0 for 1 cycle after the 2nd payload byte -> all outputs 0, count=0, dout_valid=0; scenario 1 then passes cleanly.
6. ROUTER_REG_ERRCNT_EN defined, two packets per scenario 2 -> err_cnt=2; undefined -> err_cnt=0.
